// File: rtl/gps_pkg.sv
// Shared GPS definitions: stream selection, host read opcodes and stream-length helpers.
package gps_pkg;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_SRQ,
        SEL_SNAP,
        SEL_OVR
    } sel_e;

    localparam logic [3:0] GET_SRQ      = 4'h1;
    localparam logic [3:0] GET_SNAPSHOT = 4'h2;
    localparam logic [3:0] GET_OVR      = 4'h3;

    function automatic int unsigned srq_len(input int unsigned nchan);
        return nchan + 1;
    endfunction

    function automatic int unsigned snap_len(input int unsigned nchan,
                                             input int unsigned repl_w,
                                             input int unsigned tick_w);
        return tick_w + nchan + nchan * repl_w;
    endfunction

    function automatic int unsigned ovr_len(input int unsigned nchan, input int unsigned ovr_w);
        return nchan + ovr_w;
    endfunction

    function automatic int unsigned stream_w(input int unsigned nchan, input int unsigned repl_w,
                                             input int unsigned tick_w, input int unsigned ovr_w);
        int unsigned w;
        w = srq_len(nchan);
        if (snap_len(nchan, repl_w, tick_w) > w) w = snap_len(nchan, repl_w, tick_w);
        if (ovr_len(nchan, ovr_w) > w) w = ovr_len(nchan, ovr_w);
        return w;
    endfunction

endpackage

// File: rtl/gps_srq_serializer_if.sv
// Host-side bundle of the GPS SRQ/snapshot serializer: request inputs, load strobes, serial out.
interface gps_srq_serializer_if #(
    parameter int unsigned NCHAN  = 12,
    parameter int unsigned REPL_W = 10,
    parameter int unsigned TICK_W = 48
) ();
    logic [NCHAN-1:0]        chan_srq;
    logic                    host_srq;
    logic [NCHAN-1:0]        chan_mask;
    logic [TICK_W-1:0]       ticks;
    logic [NCHAN*REPL_W-1:0] replicas;
    logic                    ld_srq;
    logic                    ld_snap;
    logic                    ld_ovr;
    logic                    rd_bit;
    logic                    ser;
    logic                    ser_last;
    logic [4:0]              next_chan;
    logic                    next_valid;

    modport master (
        output chan_srq, host_srq, chan_mask, ticks, replicas,
        output ld_srq, ld_snap, ld_ovr, rd_bit,
        input  ser, ser_last, next_chan, next_valid
    );

    modport slave (
        input  chan_srq, host_srq, chan_mask, ticks, replicas,
        input  ld_srq, ld_snap, ld_ovr, rd_bit,
        output ser, ser_last, next_chan, next_valid
    );
endinterface

// File: rtl/gps_prio_enc.sv
// Lowest-set-bit priority encoder with a valid flag.
module gps_prio_enc #(
    parameter int unsigned Width = 8,
    parameter int unsigned IdxW  = 3
) (
    input  logic [Width-1:0] req_i,
    output logic [IdxW-1:0]  idx_o,
    output logic             valid_o
);
    always_comb begin
        idx_o   = '0;
        valid_o = |req_i;
        // Scan downwards so the lowest set bit is the last one written.
        for (int i = int'(Width) - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = IdxW'(i);
        end
    end
endmodule

// File: rtl/gps_srq_serializer.sv
// Accumulates channel/host service requests and serialises SRQ, snapshot or overrun words MSB-first.
module gps_srq_serializer
    import gps_pkg::*;
#(
    parameter int unsigned NCHAN  = 12,
    parameter int unsigned REPL_W = 10,
    parameter int unsigned TICK_W = 48,
    parameter int unsigned OVR_W  = 8
) (
    input logic             clk,
    input logic             rst,
    gps_srq_serializer_if.slave bus
);
    localparam int unsigned SrqLen  = srq_len(NCHAN);
    localparam int unsigned SnapLen = snap_len(NCHAN, REPL_W, TICK_W);
    localparam int unsigned OvrLen  = ovr_len(NCHAN, OVR_W);
    localparam int unsigned SW      = stream_w(NCHAN, REPL_W, TICK_W, OVR_W);
    localparam int unsigned BlW     = $clog2(SW + 1);
    localparam int unsigned SumW    = OVR_W + 6;
    localparam logic [OVR_W-1:0] CntMax = '1;

    logic [NCHAN:0]   flags, noted_q, noted_d;
    logic [NCHAN-1:0] ovr_q, ovr_d, new_ovr;
    logic [OVR_W-1:0] cnt_q, cnt_d;
    logic [SumW-1:0]  cnt_sum;
    logic [SW-1:0]    shift_q, shift_d;
    logic [BlW-1:0]   left_q, left_d;
    sel_e             sel_q, sel_d;
    logic             acc_snap, acc_srq, acc_ovr;
    logic [SrqLen-1:0]  srq_vec;
    logic [SnapLen-1:0] snap_vec;
    logic [OvrLen-1:0]  ovr_vec;
    logic [4:0]       enc_idx, next_chan_q;
    logic             enc_valid, next_valid_q;

    assign flags    = {bus.host_srq, bus.chan_srq};
    assign acc_snap = bus.ld_snap;
    assign acc_srq  = bus.ld_srq & ~bus.ld_snap;
    assign acc_ovr  = bus.ld_ovr & ~bus.ld_snap & ~bus.ld_srq;

    assign srq_vec  = noted_q & {1'b1, bus.chan_mask};
    assign snap_vec = {bus.ticks, bus.chan_srq | noted_q[NCHAN-1:0], bus.replicas};
    assign ovr_vec  = {ovr_q, cnt_q};

    // A pulse landing on an already-noted channel is lost unless the host drains noted now.
    assign new_ovr = bus.chan_srq & noted_q[NCHAN-1:0] & {NCHAN{~acc_srq}};

    always_comb begin
        ovr_d   = (acc_ovr ? '0 : ovr_q) | new_ovr;
        cnt_sum = acc_ovr ? '0 : SumW'(cnt_q);
        for (int i = 0; i < int'(NCHAN); i++) begin
            cnt_sum = cnt_sum + SumW'(new_ovr[i]);
        end
        cnt_d = (cnt_sum > SumW'(CntMax)) ? CntMax : cnt_sum[OVR_W-1:0];
    end

    always_comb begin
        noted_d = acc_srq ? flags : (noted_q | flags);
        shift_d = shift_q;
        left_d  = left_q;
        sel_d   = sel_q;
        if (acc_snap) begin
            shift_d = SW'(snap_vec) << (SW - SnapLen);
            left_d  = BlW'(SnapLen - 1);
            sel_d   = SEL_SNAP;
        end else if (acc_srq) begin
            shift_d = SW'(srq_vec) << (SW - SrqLen);
            left_d  = BlW'(SrqLen - 1);
            sel_d   = SEL_SRQ;
        end else if (acc_ovr) begin
            shift_d = SW'(ovr_vec) << (SW - OvrLen);
            left_d  = BlW'(OvrLen - 1);
            sel_d   = SEL_OVR;
        end else if (bus.rd_bit && sel_q != SEL_NONE) begin
            if (left_q != '0) begin
                shift_d = shift_q << 1;
                left_d  = left_q - BlW'(1);
            end else begin
                shift_d = '0;
                sel_d   = SEL_NONE;
            end
        end
    end

    gps_prio_enc #(
        .Width(NCHAN),
        .IdxW (5)
    ) u_next_enc (
        .req_i  (noted_q[NCHAN-1:0] & bus.chan_mask),
        .idx_o  (enc_idx),
        .valid_o(enc_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            noted_q      <= '0;
            ovr_q        <= '0;
            cnt_q        <= '0;
            shift_q      <= '0;
            left_q       <= '0;
            sel_q        <= SEL_NONE;
            next_chan_q  <= '0;
            next_valid_q <= 1'b0;
        end else begin
            noted_q      <= noted_d;
            ovr_q        <= ovr_d;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            left_q       <= left_d;
            sel_q        <= sel_d;
            next_chan_q  <= enc_idx;
            next_valid_q <= enc_valid;
        end
    end

    assign bus.ser        = shift_q[SW-1];
    assign bus.ser_last   = (left_q == '0) && (sel_q != SEL_NONE);
    assign bus.next_chan  = next_chan_q;
    assign bus.next_valid = next_valid_q;
endmodule
